alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: turns raw active-low operation buttons into single,
// latched ALU operations. Each operation waits LAT settle cycles before
// capturing the result and flags, then waits for all buttons to be released.
module alu_sequencer #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic [3:0]   operations_buttons,
  input  logic [1:0]   change_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  output logic [1:0]   alu_mode,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] result_reg,
  output logic [3:0]   flags_reg,
  output logic         busy,
  output logic         done,
  output logic         op_err,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, HOLD} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_btn_m;
  logic [3:0] r_btn_s;
  logic [3:0] r_btn_p;
  logic [1:0] r_settle;
  logic       r_arm;
  logic [3:0] r_cnt;
  logic [3:0] w_btn_n;
  logic       w_one_zero;
  logic       w_press;
  logic       w_valid;
  logic       w_start;
  logic       w_reject;
  logic       w_finish;

  // A button that is still held when reset is released must not count as a
  // fresh press: presses are only armed once the synchronizer has flushed
  // and has seen every button released.
  assign w_btn_n    = ~r_btn_s;
  assign w_one_zero = (w_btn_n != 4'd0) && ((w_btn_n & (w_btn_n - 4'd1)) == 4'd0);
  assign w_press    = r_arm && (r_btn_p == 4'hF) && (r_btn_s != 4'hF);
  assign w_valid    = w_one_zero && (change_mode != 2'b11);

  // Two-flop synchronizer, previous-value register and post-reset arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_m  <= 4'hF;
      r_btn_s  <= 4'hF;
      r_btn_p  <= 4'hF;
      r_settle <= 2'd0;
      r_arm    <= 1'b0;
    end else begin
      r_btn_m <= operations_buttons;
      r_btn_s <= r_btn_m;
      r_btn_p <= r_btn_s;
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd2) && (r_btn_s == 4'hF)) begin
        r_arm <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the busy/done outputs, which follow the state directly.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_reject     = 1'b0;
    w_finish     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press) begin
          if (w_valid) begin
            w_start      = 1'b1;
            w_state_next = EXEC;
          end else begin
            w_reject     = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        if (r_btn_s == 4'hF) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, settle counter, result capture and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= 2'b00;
      alu_op     <= 4'hF;
      op_err     <= 1'b0;
      r_cnt      <= 4'd0;
      result_reg <= '0;
      flags_reg  <= 4'd0;
      op_count   <= 8'd0;
    end else begin
      if (w_start) begin
        alu_a    <= A_num;
        alu_b    <= B_num;
        alu_mode <= change_mode;
        alu_op   <= r_btn_s;
        op_err   <= 1'b0;
        r_cnt    <= 4'(LAT - 1);
      end else if ((r_state == EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_reject) begin
        op_err <= 1'b1;
      end
      if (w_finish) begin
        result_reg <= alu_result;
        flags_reg  <= alu_flags;
        op_count   <= op_count + 8'd1;
      end
      // Leaving DONE always enters HOLD, where no operation is driven.
      if (r_state == DONE) begin
        alu_op <= 4'hF;
      end
    end
  end

endmodule
